// File: rtl/vga_draw_pkg.sv
// Shared constants and state typedef for the VGA drawing arbiter and future sprite layer.
package vga_draw_pkg;

    localparam int SCREEN_W       = 160;
    localparam int SCREEN_H       = 120;
    localparam int DEF_X_W        = 8;
    localparam int DEF_Y_W        = 7;
    localparam int DEF_C_W        = 3;
    localparam int DEF_KEY_COLOUR = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner select: first set request bit at or after the start index, wrapping.
// With rr_mode_i low the search always starts at index 0 (fixed priority).
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    input  logic             rr_mode_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;

    function automatic int unsigned wrap_idx(input int unsigned b, input int unsigned k);
        return (b + k) % N;
    endfunction

    assign base = rr_mode_i ? start_i : '0;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'(wrap_idx(32'(base), k));
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Arbitrates pixel bursts from several drawing sources onto a single vga_adapter port,
// with optional colour-key transparency and a one-cycle registered pixel path.
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int C_W        = DEF_C_W,
    parameter int RR_MODE    = 1,
    parameter int KEY_COLOUR = DEF_KEY_COLOUR
) (
    input  logic                       CLOCK_50,
    input  logic                       Reset,
    input  logic [N_SRC-1:0]           src_req,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC-1:0]           src_last,
    input  logic [N_SRC-1:0]           src_key_en,
    input  logic [N_SRC*X_W-1:0]       src_x,
    input  logic [N_SRC*Y_W-1:0]       src_y,
    input  logic [N_SRC*C_W-1:0]       src_colour,
    output logic [N_SRC-1:0]           src_grant,
    output logic [N_SRC-1:0]           src_ready,
    output logic [X_W-1:0]             vgaX,
    output logic [Y_W-1:0]             vgaY,
    output logic [C_W-1:0]             vgaColour,
    output logic                       plot,
    output logic                       busy,
    output logic [$clog2(N_SRC)-1:0]   owner
);

    localparam int              OW    = $clog2(N_SRC);
    localparam logic [C_W-1:0]  KEY_C = C_W'(KEY_COLOUR);

    arb_state_e       state_q,  state_d;
    logic [OW-1:0]    owner_q,  owner_d;
    logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0] grant_q,  grant_d;
    logic [X_W-1:0]   vga_x_q,  vga_x_d;
    logic [Y_W-1:0]   vga_y_q,  vga_y_d;
    logic [C_W-1:0]   vga_c_q,  vga_c_d;
    logic             plot_q,   plot_d;

    logic [N_SRC-1:0] pick_grant;
    logic [OW-1:0]    pick_idx;
    logic             pick_valid;

    logic             xfer;
    logic             cur_last;
    logic             cur_key;
    logic [X_W-1:0]   cur_x;
    logic [Y_W-1:0]   cur_y;
    logic [C_W-1:0]   cur_colour;

    rr_priority_picker #(
        .N     (N_SRC),
        .IDX_W (OW)
    ) u_picker (
        .req_i     (src_req),
        .start_i   (rr_ptr_q),
        .rr_mode_i (RR_MODE != 0),
        .grant_o   (pick_grant),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    // Only the owner's lanes are ever looked at; everything else is ignored.
    assign xfer       = (state_q == ST_SERVE) && src_valid[owner_q];
    assign cur_last   = src_last[owner_q];
    assign cur_key    = src_key_en[owner_q];
    assign cur_x      = src_x[int'(owner_q)*X_W +: X_W];
    assign cur_y      = src_y[int'(owner_q)*Y_W +: Y_W];
    assign cur_colour = src_colour[int'(owner_q)*C_W +: C_W];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        vga_x_d  = vga_x_q;
        vga_y_d  = vga_y_q;
        vga_c_d  = vga_c_q;
        plot_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_SERVE;
                    owner_d = pick_idx;
                    grant_d = pick_grant;
                end
            end
            ST_SERVE: begin
                if (xfer) begin
                    vga_x_d = cur_x;
                    vga_y_d = cur_y;
                    vga_c_d = cur_colour;
                    plot_d  = !(cur_key && (cur_colour == KEY_C));
                    if (cur_last) begin
                        state_d = ST_RELEASE;
                        grant_d = '0;
                    end
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (owner_q == OW'(N_SRC - 1)) ? '0 : owner_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            vga_x_q  <= '0;
            vga_y_q  <= '0;
            vga_c_q  <= '0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            vga_x_q  <= vga_x_d;
            vga_y_q  <= vga_y_d;
            vga_c_q  <= vga_c_d;
            plot_q   <= plot_d;
        end
    end

    // grant_q is cleared outside SERVE, so it doubles as the ready vector.
    assign src_grant = grant_q;
    assign src_ready = grant_q;
    assign vgaX      = vga_x_q;
    assign vgaY      = vga_y_q;
    assign vgaColour = vga_c_q;
    assign plot      = plot_q;
    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;

endmodule

// File: doc/vga_draw_arbiter.md
VGA_DRAW_ARBITER -- requirements
Module: vga_draw_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of drawing sources (background, rocket, asteroids, HUD, ...); legal range 2..8.
REQ-002 Parameter X_W, default 8: pixel X width (160-wide screen).
REQ-003 Parameter Y_W, default 7: pixel Y width (120-high screen).
REQ-004 Parameter C_W, default 3: colour width.
REQ-005 Parameter RR_MODE, default 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
REQ-006 Parameter KEY_COLOUR, default 0: transparent colour value.
REQ-007 CLOCK_50  in  1: single clock; all logic on its rising edge.
REQ-008 Reset  in  1: synchronous, active-high reset.
REQ-009 src_req  in  N_SRC: source i requests a drawing burst.
REQ-010 src_valid  in  N_SRC: source i presents a pixel.
REQ-011 src_last  in  N_SRC: the presented pixel is the last of the burst.
REQ-012 src_key_en  in  N_SRC: enables transparency skipping for source i.
REQ-013 src_x  in  N_SRC*X_W; src_y  in  N_SRC*Y_W; src_colour  in  N_SRC*C_W: packed pixel data, with source i in slice i.
REQ-014 src_grant  out  N_SRC: one-hot burst owner; all zeros when no source owns the bus.
REQ-015 src_ready  out  N_SRC: the owner may transfer a pixel this cycle.
REQ-016 vgaX  out  X_W; vgaY  out  Y_W; vgaColour  out  C_W; plot  out  1: registered outputs to vga_adapter.
REQ-017 busy  out  1: high whenever the FSM is not in IDLE.
REQ-018 owner  out  clog2(N_SRC): index of the current owner; holds its last value while idle.

Function
REQ-019 The FSM SHALL have three states: IDLE, SERVE and RELEASE.
REQ-020 IDLE: when any src_req is high, the arbiter picks a winner, asserts src_grant and owner on the next edge, and moves to SERVE. With no request it stays in IDLE.
REQ-021 Fixed priority: the lowest requesting index wins.
REQ-022 Round-robin: the search starts at rr_ptr and wraps modulo N_SRC.
REQ-023 SERVE: src_ready[owner] = 1 combinationally; every other src_ready bit is 0.
REQ-024 A pixel transfers when src_valid[owner] and src_ready[owner] are both high.
REQ-025 Latency: a pixel accepted at cycle t produces vgaX, vgaY, vgaColour and plot=1 at cycle t+1, i.e. one cycle, at full throughput of one pixel per cycle.
REQ-026 If src_key_en[owner]=1 and the colour equals KEY_COLOUR, the pixel is accepted but plot=0; vgaX, vgaY and vgaColour still update.
REQ-027 Any cycle with no transfer produces plot=0.
REQ-028 During SERVE, src_req, src_valid and src_last from non-owners are ignored.
REQ-029 The grant is held until the owner's src_last is transferred; dropping src_req during SERVE has no effect.
REQ-030 When the transfer carries src_last, the FSM moves to RELEASE. Both the last pixel's plot and the RELEASE cycle fall on cycle t+1.
REQ-031 RELEASE: src_grant = 0 and src_ready = 0. rr_ptr becomes (owner+1) mod N_SRC, wrapping N_SRC-1 to 0. The FSM then moves to IDLE.
REQ-032 A source may re-request immediately; in round-robin mode it cannot win ahead of another waiting requester.
REQ-033 Single-pixel burst (valid and last in the first SERVE cycle) is legal: the sequence is grant, 1 plot, RELEASE.
REQ-034 src_last without src_valid is ignored.

Reset
REQ-035 While Reset=1 at an edge, the following SHALL take these values on that edge, regardless of state (including mid-burst):
- state = IDLE
- src_grant = 0, src_ready = 0
- plot = 0, vgaX = 0, vgaY = 0, vgaColour = 0
- busy = 0, owner = 0, rr_ptr = 0
REQ-036 A pixel accepted in the cycle Reset rises SHALL NOT be plotted.

Structure
REQ-037 Shared package vga_draw_pkg: screen width/height constants, default X_W/Y_W/C_W, state encoding typedef, KEY_COLOUR default.
REQ-038 One sub-module, rr_priority_picker: combinational winner select (req vector, start pointer, mode) to one-hot and index outputs; reused by the future sprite layer.
REQ-039 Estimated size is about 200 RTL lines; no memories.

Verification
REQ-040 Fixed priority (RR_MODE=0): src_req=4'b0110 in IDLE -> grant=4'b0010 next cycle, owner=1.
REQ-041 Round-robin: sources 0 and 2 request continuously with 2-pixel bursts -> grant order 0,2,0,2; exactly one RELEASE cycle between bursts; busy low only in the IDLE cycles.
REQ-042 Throughput/latency: owner 0 streams (5,7,3'b010), (6,7,3'b010), last (7,7,3'b010) with valid held high -> plot high for 3 consecutive cycles, each 1 cycle after acceptance, coordinates in order.
REQ-043 Transparency: key_en=1, colour 3'b000 at (10,20) -> plot=0 with vgaX=10; the same pixel with key_en=0 -> plot=1.
REQ-044 Reset mid-burst: Reset=1 on the second pixel of a 4-pixel burst -> next cycle grant=0, plot=0, busy=0, state IDLE; an outstanding request is regranted after Reset falls.
REQ-045 Wrap: N_SRC=4, RR_MODE=1, only source 3 requests then releases -> rr_ptr=0; the next request set {3,0} is granted to 0.
